// File: rtl/bht_ctrl.sv
// Branch history table of 2-bit saturating counters: init sweep, predict lookups and
// read-modify-write updates on one table port. Define BHT_STATS_EN for upd_cnt/skip_cnt.
module bht_ctrl #(
  parameter int unsigned IDX_W      = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pred_req,
  input  logic [IDX_W-1:0] pred_idx,
  output logic             pred_ready,
  output logic             pred_vld,
  output logic             pred_taken,
  input  logic             upd_req,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_torn,
  output logic             upd_ready,
`ifdef BHT_STATS_EN
  output logic             busy,
  output logic [15:0]      upd_cnt,
  output logic [15:0]      skip_cnt
`else
  output logic             busy
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  localparam logic [1:0] StInit  = 2'd0;
  localparam logic [1:0] StIdle  = 2'd1;
  localparam logic [1:0] StUpdRd = 2'd2;
  localparam logic [1:0] StUpdWr = 2'd3;

  logic [1:0]       table_q [DEPTH];
  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             last_upd_q, last_upd_d;
  logic             pred_vld_q, pred_vld_d;
  logic             pred_taken_q, pred_taken_d;
  logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
  logic             upd_torn_q, upd_torn_d;
  logic [1:0]       hold_q, hold_d;

  logic             idle, grant_pred, grant_upd;
  logic             wr_skip;
  logic [1:0]       ctr_next;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_waddr;
  logic [1:0]       tbl_wdata;

  // Arbitration: with both pending, update wins unless it won the previous grant.
  assign idle       = (state_q == StIdle);
  assign pred_ready = idle && (!upd_req || last_upd_q);
  assign upd_ready  = idle && (!pred_req || !last_upd_q);
  assign grant_pred = pred_req && pred_ready;
  assign grant_upd  = upd_req && upd_ready;
  assign busy       = (state_q == StInit);
  assign pred_vld   = pred_vld_q;
  assign pred_taken = pred_taken_q;

  always_comb begin
    wr_skip  = ((hold_q == 2'b00) && !upd_torn_q) || ((hold_q == 2'b11) && upd_torn_q);
    ctr_next = upd_torn_q ? hold_q + 2'd1 : hold_q - 2'd1;
  end

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = ptr_q;
    tbl_wdata = INIT_STATE;
    if (state_q == StInit) begin
      tbl_we = 1'b1;
    end else if ((state_q == StUpdWr) && !wr_skip) begin
      tbl_we    = 1'b1;
      tbl_waddr = upd_idx_q;
      tbl_wdata = ctr_next;
    end
  end

  // Table contents are deliberately not reset; the init sweep rewrites every entry.
  always_ff @(posedge clk) begin
    if (tbl_we) begin
      table_q[tbl_waddr] <= tbl_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_upd_d   = last_upd_q;
    upd_idx_d    = upd_idx_q;
    upd_torn_d   = upd_torn_q;
    hold_d       = hold_q;
    pred_vld_d   = grant_pred;
    pred_taken_d = grant_pred ? table_q[pred_idx][1] : pred_taken_q;
    case (state_q)
      StInit: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (&ptr_q) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (grant_upd) begin
          upd_idx_d  = upd_idx;
          upd_torn_d = upd_torn;
          last_upd_d = 1'b1;
          state_d    = StUpdRd;
        end else if (grant_pred) begin
          last_upd_d = 1'b0;
        end
      end
      StUpdRd: begin
        hold_d  = table_q[upd_idx_q];
        state_d = StUpdWr;
      end
      StUpdWr: state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StInit;
      ptr_q        <= '0;
      last_upd_q   <= 1'b0;
      pred_vld_q   <= 1'b0;
      pred_taken_q <= 1'b0;
      upd_idx_q    <= '0;
      upd_torn_q   <= 1'b0;
      hold_q       <= 2'b00;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_upd_q   <= last_upd_d;
      pred_vld_q   <= pred_vld_d;
      pred_taken_q <= pred_taken_d;
      upd_idx_q    <= upd_idx_d;
      upd_torn_q   <= upd_torn_d;
      hold_q       <= hold_d;
    end
  end

`ifdef BHT_STATS_EN
  logic [15:0] upd_cnt_q, skip_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upd_cnt_q  <= 16'd0;
      skip_cnt_q <= 16'd0;
    end else if (state_q == StInit) begin
      upd_cnt_q  <= 16'd0;
      skip_cnt_q <= 16'd0;
    end else if (state_q == StUpdWr) begin
      upd_cnt_q <= upd_cnt_q + 16'd1;
      if (wr_skip) begin
        skip_cnt_q <= skip_cnt_q + 16'd1;
      end
    end
  end

  assign upd_cnt  = upd_cnt_q;
  assign skip_cnt = skip_cnt_q;
`endif

endmodule

// File: tb/tb_bht_ctrl.sv
// Scoreboard bench for bht_ctrl (IDX_W=3): expected predictions are queued at issue
// and popped by a monitor whenever pred_vld is seen.
module tb_bht_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pred_req = 1'b0;
  logic [2:0] pred_idx = 3'd0;
  logic       pred_ready, pred_vld, pred_taken;
  logic       upd_req = 1'b0;
  logic [2:0] upd_idx = 3'd0;
  logic       upd_torn = 1'b0;
  logic       upd_ready, busy;
`ifdef BHT_STATS_EN
  logic [15:0] upd_cnt, skip_cnt;
`endif

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic exp_q[$];

  bht_ctrl #(.IDX_W(3), .INIT_STATE(2'b01)) dut (
    .clk        (clk),
    .reset      (reset),
    .pred_req   (pred_req),
    .pred_idx   (pred_idx),
    .pred_ready (pred_ready),
    .pred_vld   (pred_vld),
    .pred_taken (pred_taken),
    .upd_req    (upd_req),
    .upd_idx    (upd_idx),
    .upd_torn   (upd_torn),
    .upd_ready  (upd_ready),
`ifdef BHT_STATS_EN
    .busy       (busy),
    .upd_cnt    (upd_cnt),
    .skip_cnt   (skip_cnt)
`else
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every pred_vld strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (pred_vld) begin
      if (exp_q.size() == 0) begin
        chk("pred_vld_unexpected", 32'd1, 32'd0);
      end else begin
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic predict(input logic [2:0] idx, input logic exp);
    logic seen = 1'b0;
    pred_req = 1'b1;
    pred_idx = idx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pred_ready) begin
        seen = 1'b1;
        exp_q.push_back(exp);
        break;
      end
    end
    if (!seen) chk("pred_grant_timeout", 32'd0, 32'd1);
    sync();
  endtask

  task automatic grant_upd(input logic [2:0] idx, input logic torn, output int gcyc);
    upd_req  = 1'b1;
    upd_idx  = idx;
    upd_torn = torn;
    gcyc     = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (upd_ready) begin
        gcyc = cyc;
        break;
      end
    end
    if (gcyc < 0) chk("upd_grant_timeout", 32'd0, 32'd1);
    sync();
  endtask

  // RD and WR cycles of an update: no grants possible.
  task automatic occupancy();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("upd_ready_busy", {31'd0, upd_ready}, 32'd0);
      chk("pred_ready_busy", {31'd0, pred_ready}, 32'd0);
    end
  endtask

  task automatic sweep_check();
    int n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("sweep_len", n, 32'd8);
    chk("ready_after_sweep", {31'd0, pred_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         g1, g2;
    logic [8:0] exp_u, exp_p;
`ifdef BHT_STATS_EN
    logic [15:0] u0, s0;
`endif
    // Reset values
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_pred_ready", {31'd0, pred_ready}, 32'd0);
    chk("rst_upd_ready", {31'd0, upd_ready}, 32'd0);
    chk("rst_pred_vld", {31'd0, pred_vld}, 32'd0);
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    sync();
    reset = 1'b0;
    sweep_check();
    sync();
`ifdef BHT_STATS_EN
    chk("stats_upd_init", {16'd0, upd_cnt}, 32'd0);
    chk("stats_skip_init", {16'd0, skip_cnt}, 32'd0);
`endif

    // Back-to-back predicts over the freshly initialised table
    for (int i = 0; i < 8; i++) predict(3'(i), 1'b0);
    pred_req = 1'b0;

    // Two taken updates to idx 5: 01 -> 10 -> 11
    grant_upd(3'd5, 1'b1, g1);
    occupancy();
    grant_upd(3'd5, 1'b1, g2);
    upd_req = 1'b0;
    chk("upd_spacing", g2 - g1, 32'd3);
    occupancy();
    predict(3'd5, 1'b1);
    pred_req = 1'b0;

    // Not-taken updates to idx 2: 01 -> 00, then saturated (write suppressed)
`ifdef BHT_STATS_EN
    u0 = upd_cnt;
    s0 = skip_cnt;
`endif
    grant_upd(3'd2, 1'b0, g1);
    upd_req = 1'b0;
    occupancy();
    grant_upd(3'd2, 1'b0, g1);
    upd_req = 1'b0;
    occupancy();
    sync();
`ifdef BHT_STATS_EN
    chk("stats_upd_delta", {16'd0, upd_cnt - u0}, 32'd2);
    chk("stats_skip_delta", {16'd0, skip_cnt - s0}, 32'd1);
`endif
    predict(3'd2, 1'b0);
    pred_req = 1'b0;
    // Entry must be 00: one taken step gives 01 (not taken), a second gives 10
    grant_upd(3'd2, 1'b1, g1);
    upd_req = 1'b0;
    occupancy();
    predict(3'd2, 1'b0);
    pred_req = 1'b0;
    grant_upd(3'd2, 1'b1, g1);
    upd_req = 1'b0;
    occupancy();
    predict(3'd2, 1'b1);
    pred_req = 1'b0;

    // Both requesters held; last grant was a predict so update goes first
    exp_u = 9'b1_0001_0001;
    exp_p = 9'b0_1000_1000;
    pred_req = 1'b1;
    pred_idx = 3'd6;
    upd_req  = 1'b1;
    upd_idx  = 3'd6;
    upd_torn = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      chk($sformatf("arb_upd_c%0d", c), {31'd0, upd_ready}, {31'd0, exp_u[c]});
      chk($sformatf("arb_pred_c%0d", c), {31'd0, pred_ready}, {31'd0, exp_p[c]});
      if (pred_ready) exp_q.push_back(1'b1);
    end
    sync();
    pred_req = 1'b0;
    upd_req  = 1'b0;

    // Drive idx 4 to 11, then reset during the RD cycle of a third update
    grant_upd(3'd4, 1'b1, g1);
    upd_req = 1'b0;
    occupancy();
    grant_upd(3'd4, 1'b1, g1);
    upd_req = 1'b0;
    occupancy();
    predict(3'd4, 1'b1);
    pred_req = 1'b0;
    grant_upd(3'd4, 1'b0, g1);
    upd_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_pred_ready", {31'd0, pred_ready}, 32'd0);
    chk("mid_rst_upd_ready", {31'd0, upd_ready}, 32'd0);
    chk("mid_rst_pred_vld", {31'd0, pred_vld}, 32'd0);
    chk("mid_rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sweep_check();
    sync();
`ifdef BHT_STATS_EN
    chk("stats_upd_reinit", {16'd0, upd_cnt}, 32'd0);
`endif
    predict(3'd4, 1'b0);
    predict(3'd6, 1'b0);
    pred_req = 1'b0;

    // Single predict followed by an idle cycle
    grant_upd(3'd5, 1'b1, g1);
    upd_req = 1'b0;
    occupancy();
    predict(3'd5, 1'b1);
    pred_req = 1'b0;
    @(negedge clk);
    chk("strobe_high", {31'd0, pred_vld}, 32'd1);
    @(negedge clk);
    chk("strobe_low", {31'd0, pred_vld}, 32'd0);
    chk("taken_held", {31'd0, pred_taken}, 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
